// File: rtl/ae_seq_core.sv
// ============================================================================
// Module   : ae_seq_core
// Brief    : Self-sequencing fixed-point autoencoder core (fetch/exec/wb FSM).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ae_seq_core #(
  parameter int DATA_W     = 16,
  parameter int FRAC_W     = 8,
  parameter int NREG       = 16,
  parameter int IMEM_DEPTH = 32,
  localparam int RA_W      = $clog2(NREG),
  localparam int PC_W      = $clog2(IMEM_DEPTH),
  localparam int INSTR_W   = 4 + 3*RA_W
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               prog_we,
  input  logic [PC_W-1:0]    prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  input  logic               ext_we,
  input  logic [RA_W-1:0]    ext_addr,
  input  logic [DATA_W-1:0]  ext_wdata,
  output logic [DATA_W-1:0]  ext_rdata,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int WW = 2*DATA_W + 2;

  localparam logic [2:0] c_st_idle  = 3'd0;
  localparam logic [2:0] c_st_fetch = 3'd1;
  localparam logic [2:0] c_st_exec  = 3'd2;
  localparam logic [2:0] c_st_wb    = 3'd3;
  localparam logic [2:0] c_st_done  = 3'd4;

  localparam logic [3:0] c_op_nop     = 4'd0;
  localparam logic [3:0] c_op_add     = 4'd1;
  localparam logic [3:0] c_op_sub     = 4'd2;
  localparam logic [3:0] c_op_mul     = 4'd3;
  localparam logic [3:0] c_op_addrelu = 4'd4;
  localparam logic [3:0] c_op_addsig  = 4'd5;
  localparam logic [3:0] c_op_sigd    = 4'd6;
  localparam logic [3:0] c_op_mov     = 4'd7;
  localparam logic [3:0] c_op_halt    = 4'd15;

  localparam logic signed [WW-1:0] c_sat_max = {{(WW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [WW-1:0] c_sat_min = {{(WW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  localparam logic signed [WW-1:0] c_one     = {{(WW-FRAC_W-1){1'b0}}, 1'b1, {FRAC_W{1'b0}}};
  localparam logic signed [WW-1:0] c_half    = {{(WW-FRAC_W){1'b0}}, 1'b1, {(FRAC_W-1){1'b0}}};

  logic [2:0]         r_state;
  logic [2:0]         w_state_nxt;
  logic [INSTR_W-1:0] r_imem [IMEM_DEPTH];
  logic [DATA_W-1:0]  r_regs [NREG];
  logic [PC_W-1:0]    r_pc;
  logic [INSTR_W-1:0] r_ir;
  logic [DATA_W-1:0]  r_result;
  logic               r_err;
  logic [DATA_W-1:0]  r_rdata;

  logic [3:0]         w_op;
  logic [RA_W-1:0]    w_src1;
  logic [RA_W-1:0]    w_src2;
  logic [RA_W-1:0]    w_dst;
  logic               w_illegal;
  logic               w_pc_last;
  logic [DATA_W-1:0]  w_ra;
  logic [DATA_W-1:0]  w_rb;
  logic signed [WW-1:0] w_a;
  logic signed [WW-1:0] w_b;
  logic signed [WW-1:0] w_sum;
  logic signed [WW-1:0] w_diff;
  logic signed [WW-1:0] w_prod;
  logic signed [WW-1:0] w_sigd;
  logic [DATA_W-1:0]    w_sum_sat;
  logic signed [WW-1:0] w_sum_sat_x;
  logic signed [WW-1:0] w_hsig;
  logic signed [WW-1:0] w_res_x;
  logic [DATA_W-1:0]    w_result;

  function automatic logic [DATA_W-1:0] sat(input logic signed [WW-1:0] v);
    if (v > c_sat_max)      return c_sat_max[DATA_W-1:0];
    else if (v < c_sat_min) return c_sat_min[DATA_W-1:0];
    else                    return v[DATA_W-1:0];
  endfunction

  assign w_op      = r_ir[INSTR_W-1 -: 4];
  assign w_src1    = r_ir[3*RA_W-1 -: RA_W];
  assign w_src2    = r_ir[2*RA_W-1 -: RA_W];
  assign w_dst     = r_ir[RA_W-1:0];
  assign w_illegal = w_op[3] && (w_op != c_op_halt);
  assign w_pc_last = (r_pc == PC_W'(IMEM_DEPTH-1));

  // Operands are widened once so every op below runs at full precision.
  assign w_ra  = r_regs[w_src1];
  assign w_rb  = r_regs[w_src2];
  assign w_a   = {{(WW-DATA_W){w_ra[DATA_W-1]}}, w_ra};
  assign w_b   = {{(WW-DATA_W){w_rb[DATA_W-1]}}, w_rb};
  assign w_sum  = w_a + w_b;
  assign w_diff = w_a - w_b;
  assign w_prod = (w_a * w_b) >>> FRAC_W;
  assign w_sigd = (w_a * (c_one - w_a)) >>> FRAC_W;

  // Activations see the already-saturated sum.
  assign w_sum_sat   = sat(w_sum);
  assign w_sum_sat_x = {{(WW-DATA_W){w_sum_sat[DATA_W-1]}}, w_sum_sat};
  assign w_hsig      = (w_sum_sat_x >>> 2) + c_half;

  always_comb begin
    w_res_x = '0;
    case (w_op)
      c_op_add:     w_res_x = w_sum;
      c_op_sub:     w_res_x = w_diff;
      c_op_mul:     w_res_x = w_prod;
      c_op_addrelu: w_res_x = (w_sum_sat_x < 0) ? '0 : w_sum_sat_x;
      c_op_addsig: begin
        if (w_hsig < 0)          w_res_x = '0;
        else if (w_hsig > c_one) w_res_x = c_one;
        else                     w_res_x = w_hsig;
      end
      c_op_sigd:    w_res_x = w_sigd;
      c_op_mov:     w_res_x = w_a;
      default:      w_res_x = '0;
    endcase
  end

  assign w_result = sat(w_res_x);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= c_st_idle;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle:  if (start) w_state_nxt = c_st_fetch;
      c_st_fetch: w_state_nxt = c_st_exec;
      c_st_exec:  w_state_nxt = ((w_op == c_op_halt) || w_illegal) ? c_st_done : c_st_wb;
      c_st_wb:    w_state_nxt = w_pc_last ? c_st_done : c_st_fetch;
      c_st_done:  w_state_nxt = c_st_idle;
      default:    w_state_nxt = c_st_idle;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      c_st_fetch, c_st_exec, c_st_wb: busy = 1'b1;
      c_st_done:                      done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pc     <= '0;
      r_ir     <= '0;
      r_result <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        c_st_idle: if (start) begin
          r_pc  <= '0;
          r_err <= 1'b0;
        end
        c_st_fetch: r_ir <= r_imem[r_pc];
        c_st_exec: begin
          r_result <= w_result;
          if (w_illegal) r_err <= 1'b1;
        end
        c_st_wb: if (!w_pc_last) r_pc <= r_pc + 1'b1;
        default: ;
      endcase
    end
  end

  // Program memory survives reset so a program can be re-run after an abort.
  always_ff @(posedge clock) begin
    if ((r_state == c_st_idle) && prog_we) r_imem[prog_addr] <= prog_data;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else if ((r_state == c_st_idle) && ext_we) begin
      r_regs[ext_addr] <= ext_wdata;
    end else if ((r_state == c_st_wb) && (w_op != c_op_nop)) begin
      r_regs[w_dst] <= r_result;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_rdata <= '0;
    else          r_rdata <= r_regs[ext_addr];
  end

  assign ext_rdata = r_rdata;
  assign err       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_ae_seq_core.sv
// ============================================================================
// Module   : tb_ae_seq_core
// Brief    : Directed self-checking bench for ae_seq_core.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ae_seq_core;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        prog_we;
  logic [4:0]  prog_addr;
  logic [15:0] prog_data;
  logic        ext_we;
  logic [3:0]  ext_addr;
  logic [15:0] ext_wdata;
  logic [15:0] ext_rdata;
  logic        start;
  logic        busy;
  logic        done;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  ae_seq_core dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .ext_we    (ext_we),
    .ext_addr  (ext_addr),
    .ext_wdata (ext_wdata),
    .ext_rdata (ext_rdata),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clock = ~clock;

  function automatic logic [15:0] ins(input logic [3:0] op, input logic [3:0] s1,
                                      input logic [3:0] s2, input logic [3:0] d);
    return {op, s1, s2, d};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic prog(input logic [4:0] a, input logic [15:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    @(negedge clock);
    prog_we = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    ext_we = 1'b1; ext_addr = a; ext_wdata = d;
    @(negedge clock);
    ext_we = 1'b0;
  endtask

  task automatic chk_reg(input string tag, input logic [3:0] a, input logic [15:0] exp);
    ext_addr = a;
    @(negedge clock);
    chk(tag, ext_rdata, exp);
  endtask

  // Pulses start (optionally with a same-cycle register write) and measures busy.
  task automatic run(input string tag, input int exp_busy, input logic we,
                     input logic [3:0] wa, input logic [15:0] wd);
    int cnt = 0;
    start = 1'b1; ext_we = we; ext_addr = wa; ext_wdata = wd;
    @(negedge clock);
    start = 1'b0; ext_we = 1'b0;
    while (busy === 1'b1 && cnt < 300) begin
      cnt++;
      @(negedge clock);
    end
    chk({tag, "_busy_cycles"}, cnt, exp_busy);
    chk({tag, "_done_pulse"}, {busy, done}, 2'b01);
    @(negedge clock);
    chk({tag, "_back_idle"}, {busy, done}, 2'b00);
  endtask

  initial begin
    #200000;
    $display("FAIL tb_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    logic [15:0] vals [10];
    reset_n = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    ext_we = 1'b0; ext_addr = '0; ext_wdata = '0; start = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_rdata", ext_rdata, 16'h0000);
    reset_n = 1'b1;
    @(negedge clock);

    // ADD then HALT
    prog(0, ins(4'd1, 4'd0, 4'd1, 4'd2));
    prog(1, ins(4'd15, 4'd0, 4'd0, 4'd0));
    wr(0, 16'h0180);
    wr(1, 16'h0040);
    run("add", 5, 1'b0, 4'd0, 16'h0);
    chk("add_err", err, 1'b0);
    chk_reg("add_r2", 2, 16'h01C0);

    // start with a simultaneous register write: program must see the new r1
    run("startwe", 5, 1'b1, 4'd1, 16'h0100);
    chk_reg("startwe_r1", 1, 16'h0100);
    chk_reg("startwe_r2", 2, 16'h0280);

    // Saturation and activations
    vals = '{16'h7F00, 16'h0200, 16'h0300, 16'h0400, 16'h0100,
             16'hFE00, 16'hFF00, 16'hFC00, 16'h0000, 16'h0080};
    for (int i = 0; i < 10; i++) wr(4'(i), vals[i]);
    prog(0, ins(4'd1, 4'd0, 4'd1, 4'd10));
    prog(1, ins(4'd3, 4'd1, 4'd2, 4'd11));
    prog(2, ins(4'd3, 4'd0, 4'd3, 4'd12));
    prog(3, ins(4'd4, 4'd4, 4'd5, 4'd13));
    prog(4, ins(4'd5, 4'd4, 4'd6, 4'd14));
    prog(5, ins(4'd5, 4'd3, 4'd8, 4'd15));
    prog(6, ins(4'd15, 4'd0, 4'd0, 4'd0));
    run("arith1", 20, 1'b0, 4'd0, 16'h0);
    chk_reg("add_sat", 10, 16'h7FFF);
    chk_reg("mul_2x3", 11, 16'h0600);
    chk_reg("mul_sat", 12, 16'h7FFF);
    chk_reg("relu_neg", 13, 16'h0000);
    chk_reg("hsig_zero", 14, 16'h0080);
    chk_reg("hsig_pos", 15, 16'h0100);

    prog(0, ins(4'd5, 4'd7, 4'd8, 4'd10));
    prog(1, ins(4'd6, 4'd9, 4'd0, 4'd11));
    prog(2, ins(4'd2, 4'd5, 4'd0, 4'd12));
    prog(3, ins(4'd7, 4'd4, 4'd0, 4'd13));
    prog(4, ins(4'd1, 4'd13, 4'd13, 4'd14));
    prog(5, ins(4'd15, 4'd0, 4'd0, 4'd0));
    run("arith2", 17, 1'b0, 4'd0, 16'h0);
    chk_reg("hsig_neg", 10, 16'h0000);
    chk_reg("sigd", 11, 16'h0040);
    chk_reg("sub_negsat", 12, 16'h8000);
    chk_reg("mov", 13, 16'h0100);
    chk_reg("raw_hazard", 14, 16'h0200);

    // Illegal opcode after a valid ADD
    wr(0, 16'h0010);
    wr(1, 16'h0020);
    prog(0, ins(4'd1, 4'd0, 4'd1, 4'd2));
    prog(1, ins(4'd9, 4'd0, 4'd0, 4'd3));
    run("illegal", 5, 1'b0, 4'd0, 16'h0);
    chk("illegal_err_idle", err, 1'b1);
    chk_reg("illegal_r2", 2, 16'h0030);
    prog(1, ins(4'd15, 4'd0, 4'd0, 4'd0));
    run("clear_err", 5, 1'b0, 4'd0, 16'h0);
    chk("err_cleared", err, 1'b0);

    // All-NOP program runs to the last slot without wrapping
    for (int i = 0; i < 32; i++) prog(5'(i), 16'h0000);
    run("nop32", 96, 1'b0, 4'd0, 16'h0);
    chk("nop32_err", err, 1'b0);
    chk_reg("nop32_r2", 2, 16'h0030);

    // Reset during EXEC of a MUL
    prog(0, ins(4'd3, 4'd0, 4'd1, 4'd2));
    prog(1, ins(4'd15, 4'd0, 4'd0, 4'd0));
    wr(0, 16'h0200);
    wr(1, 16'h0300);
    chk_reg("pre_rst_rdata", 0, 16'h0200);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    chk("in_exec_busy", busy, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_err", err, 1'b0);
    chk("midrst_rdata", ext_rdata, 16'h0000);
    @(negedge clock);
    reset_n = 1'b1;
    chk_reg("midrst_r2", 2, 16'h0000);
    chk_reg("midrst_r0", 0, 16'h0000);

    // Re-run without reloading imem; writes/start during busy are ignored
    wr(0, 16'h0200);
    wr(1, 16'h0300);
    start = 1'b1;
    @(negedge clock);
    ext_we = 1'b1; ext_addr = 4'd5; ext_wdata = 16'h1234;
    prog_we = 1'b1; prog_addr = 5'd1; prog_data = ins(4'd1, 4'd0, 4'd1, 4'd3);
    cnt = (busy === 1'b1) ? 1 : 0;
    @(negedge clock);
    start = 1'b0; ext_we = 1'b0; prog_we = 1'b0;
    while (busy === 1'b1 && cnt < 300) begin
      cnt++;
      @(negedge clock);
    end
    chk("rerun_busy_cycles", cnt, 5);
    chk("rerun_done_pulse", {busy, done}, 2'b01);
    @(negedge clock);
    chk("rerun_back_idle", {busy, done}, 2'b00);
    chk_reg("rerun_r2", 2, 16'h0600);
    chk_reg("busy_extwe_ignored", 5, 16'h0000);
    chk_reg("busy_progwe_ignored", 3, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ae_seq_core.md
# ae_seq_core

Parametrised, self-sequencing autoencoder compute core. A host loads a program into the internal instruction memory and operands into the register file, then pulses `start`. The core runs a fetch/execute/write-back FSM over `[opcode|src1|src2|dst]` instructions. It uses a saturating fixed-point ALU with fused activation (ReLU, hard sigmoid, sigmoid derivative), so one core handles both forward and backprop layer steps. The core signals completion with `done`, and an illegal opcode sets the sticky error flag `err`.

## Interface
- `DATA_W`, 16: data word width (signed two's complement)
- `FRAC_W`, 8: fractional bits; 1.0 = `1<<FRAC_W`
- `NREG`, 16: register-file depth (power of 2); `RA_W = clog2(NREG)`
- `IMEM_DEPTH`, 32: instruction memory depth (power of 2); `PC_W = clog2(IMEM_DEPTH)`
- Derived: `INSTR_W = 4 + 3*RA_W`

Ports:
- `clock`  in  1  sole clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `prog_we`  in  1  instruction-memory write strobe (honoured only in IDLE)
- `prog_addr`  in  `PC_W`  instruction write address
- `prog_data`  in  `INSTR_W`  instruction word
- `ext_we`  in  1  register-file write strobe (honoured only in IDLE)
- `ext_addr`  in  `RA_W`  register-file read/write address
- `ext_wdata`  in  `DATA_W`  register write data
- `ext_rdata`  out  `DATA_W`  registered read of `reg[ext_addr]`, one-cycle latency, valid in every state
- `start`  in  1  run request, sampled only in IDLE
- `busy`  out  1  high in FETCH, EXEC and WB
- `done`  out  1  one-cycle pulse on program end
- `err`  out  1  sticky illegal-opcode flag; cleared on an accepted `start`

## Operation
- Instruction layout:
  - opcode = `[INSTR_W-1 -: 4]`
  - src1 = next `RA_W` bits
  - src2 = next `RA_W` bits
  - dst = lowest `RA_W` bits
  - a = `reg[src1]`, b = `reg[src2]`
- Opcodes:
  - 0 NOP: no register write
  - 1 ADD: a+b
  - 2 SUB: a−b
  - 3 MUL: (a*b) >>> FRAC_W, full 2·DATA_W product
  - 4 ADDRELU: max(0, a+b)
  - 5 ADDSIG: hard sigmoid of s=a+b = clamp((s>>>2) + 0.5, 0, 1.0)
  - 6 SIGD: a·(1.0−a) >>> FRAC_W
  - 7 MOV: a
  - 15 HALT
  - 8–14 illegal
- Arithmetic rules:
  - Every intermediate is computed at full precision (ADD/SUB at DATA_W+1 bits).
  - The final result saturates to [−2^(DATA_W−1), 2^(DATA_W−1)−1].
  - For ADDRELU/ADDSIG, saturation is applied to the sum before the activation.
- FSM states: IDLE, FETCH, EXEC, WB, DONE.
  - IDLE: on `start`, clear `pc` and `err`, then go to FETCH.
  - FETCH: register `imem[pc]` into the instruction register.
  - EXEC: decode, read a/b, register the result.
    - HALT goes to DONE.
    - An illegal opcode sets `err` and goes to DONE.
    - Otherwise go to WB.
  - WB: write the result to `reg[dst]` (NOP skips the write).
    - If `pc == IMEM_DEPTH-1`, go to DONE; there is no wrap-around.
    - Otherwise increment `pc` and go to FETCH.
  - DONE: `done`=1 for one cycle, then IDLE.
- Boundary and priority rules:
  - `start`, `prog_we` and `ext_we` outside IDLE are ignored.
  - In IDLE, when `start` and `ext_we` are simultaneous, the write takes effect and `start` is also accepted; the program sees the new value.
  - `dst` equal to src1/src2 of the next instruction reads the new value, because WB completes before the next EXEC.
- Reset (`reset_n`=0) takes effect immediately at any time, including mid-program:
  - state = IDLE, `pc` = 0
  - all registers = 0
  - `busy`=0, `done`=0, `err`=0, `ext_rdata`=0
  - Instruction memory is not cleared.

## Timing
- `start` is sampled at edge T0. `busy`=1 from T0 through the final EXEC/WB.
- Each non-HALT instruction takes 3 cycles. HALT takes 2 cycles (FETCH, EXEC).
- A program of k instructions followed by HALT:
  - `busy` stays high for 3k+2 cycles.
  - `done` is high in the next cycle, with `busy`=0.
  - The core is back in IDLE one cycle later.
- A register written in WB is visible on `ext_rdata` one cycle after its address is presented.
- `err` updates at the EXEC edge and holds through DONE/IDLE until the next accepted `start`.

## Test plan
- Program ADD r2=r0+r1, HALT with r0=0x0180 (1.5), r1=0x0040 (0.25): r2=0x01C0; `busy` high 5 cycles; single `done` pulse; `err`=0.
- Saturation: ADD r0=0x7F00 + r1=0x0200 → 0x7FFF. MUL 0x0200×0x0300 (2×3) → 0x0600. MUL 0x7F00×0x0400 → 0x7FFF.
- Activations:
  - ADDRELU with a+b = −0x0100 → 0x0000.
  - ADDSIG with sum 0 → 0x0080; sum 0x0400 → 0x0100; sum −0x0400 → 0x0000.
  - SIGD with a=0x0080 → 0x0040.
- Illegal opcode 9 at pc=1 after a valid ADD: ADD result written; `err`=1 and `done` pulses after 3+2 busy cycles. The next `start` clears `err`.
- No HALT, all 32 slots NOP: `busy` for 96 cycles, then `done`; `pc` does not wrap.
- Assert `reset_n` during EXEC of a MUL: all outputs go to 0 immediately and the destination register is not written. After release, the same program re-runs correctly without reloading instruction memory; `ext_we`/`start` during `busy` have no effect.
